// File: rtl/inst_dec_pipe.sv
// Handshaked 16-bit instruction decoder with a DEPTH-entry queue of decoded bundles.
// Supports stall (I_En), synchronous flush, and a running count of accepted instructions.
module inst_dec_pipe #(
    parameter int          INST_W     = 16,
    parameter int          REG_W      = 4,
    parameter int          ALUOP_W    = 5,
    parameter int          IMM_W      = 16,
    parameter int          DEPTH      = 2,
    parameter logic [15:0] REGWE_MASK = 16'h03FF,
    parameter logic [15:0] SEXT_MASK  = 16'h3000,
    parameter int          CNT_W      = 16
) (
    input  logic               I_Clk,
    input  logic               I_Rst_n,
    input  logic               I_En,
    input  logic               I_Flush,
    input  logic               I_Valid,
    output logic               O_Ready,
    input  logic [INST_W-1:0]  I_Inst,
    output logic               O_Valid,
    input  logic               I_Ready,
    output logic [ALUOP_W-1:0] O_Aluop,
    output logic [REG_W-1:0]   O_SelD,
    output logic [REG_W-1:0]   O_SelA,
    output logic [REG_W-1:0]   O_SelB,
    output logic [IMM_W-1:0]   O_Imm,
    output logic               O_Regwe,
    output logic [CNT_W-1:0]   O_Count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int BUN_W = ALUOP_W + 3 * REG_W + IMM_W + 1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [3:0]         opcode;
    logic [ALUOP_W-1:0] dec_aluop;
    logic [IMM_W-1:0]   dec_imm;
    logic [BUN_W-1:0]   dec_bundle;

    assign opcode = I_Inst[15:12];

    always_comb begin
        dec_aluop = {opcode, I_Inst[8]};
        dec_imm   = SEXT_MASK[opcode] ? IMM_W'($signed(I_Inst[7:0]))
                                      : IMM_W'(I_Inst[7:0]);
        dec_bundle = {dec_aluop, I_Inst[11:8], I_Inst[7:4], I_Inst[3:0],
                      dec_imm, REGWE_MASK[opcode]};
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             not_full, has_data, push, pop;

    // Ready comes only from registered occupancy so it never combinationally follows I_Ready.
    assign not_full = (occ_q < OCC_W'(DEPTH));
    assign has_data = (occ_q != '0);
    assign O_Ready  = I_En & not_full;
    assign O_Valid  = has_data;
    assign push     = I_En & I_Valid & not_full & ~I_Flush;
    assign pop      = I_En & has_data & I_Ready & ~I_Flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (I_Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                cnt_d    = cnt_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge I_Clk or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    logic [BUN_W-1:0] ent_all [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [BUN_W-1:0] ent_q, ent_d;

            always_comb begin
                ent_d = ent_q;
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    ent_d = dec_bundle;
                end
            end

            always_ff @(posedge I_Clk or negedge I_Rst_n) begin
                if (!I_Rst_n) begin
                    ent_q <= '0;
                end else begin
                    ent_q <= ent_d;
                end
            end

            assign ent_all[gi] = ent_q;
        end
    endgenerate

    // Stale entries stay in storage after a pop or flush, so the head is masked when empty.
    logic [BUN_W-1:0] head;
    assign head = has_data ? ent_all[rd_ptr_q] : '0;

    assign {O_Aluop, O_SelD, O_SelA, O_SelB, O_Imm, O_Regwe} = head;
    assign O_Count = cnt_q;

endmodule

// File: tb/tb_inst_dec_pipe.sv
// Scoreboard bench for inst_dec_pipe: directed scenarios followed by random traffic.
// The driver pushes expected bundles on accepted pushes; a negedge monitor pops and compares.
module tb_inst_dec_pipe;

    localparam int DEPTH = 2;

    logic        I_Clk;
    logic        I_Rst_n;
    logic        I_En;
    logic        I_Flush;
    logic        I_Valid;
    logic        O_Ready;
    logic [15:0] I_Inst;
    logic        O_Valid;
    logic        I_Ready;
    logic [4:0]  O_Aluop;
    logic [3:0]  O_SelD;
    logic [3:0]  O_SelA;
    logic [3:0]  O_SelB;
    logic [15:0] O_Imm;
    logic        O_Regwe;
    logic [15:0] O_Count;

    inst_dec_pipe #(.DEPTH(DEPTH)) dut (
        .I_Clk   (I_Clk),
        .I_Rst_n (I_Rst_n),
        .I_En    (I_En),
        .I_Flush (I_Flush),
        .I_Valid (I_Valid),
        .O_Ready (O_Ready),
        .I_Inst  (I_Inst),
        .O_Valid (O_Valid),
        .I_Ready (I_Ready),
        .O_Aluop (O_Aluop),
        .O_SelD  (O_SelD),
        .O_SelA  (O_SelA),
        .O_SelB  (O_SelB),
        .O_Imm   (O_Imm),
        .O_Regwe (O_Regwe),
        .O_Count (O_Count)
    );

    initial I_Clk = 1'b0;
    always #5 I_Clk = ~I_Clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [33:0] exp_q [$];
    int          mocc    = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [33:0] dut_bundle;

    assign dut_bundle = {O_Aluop, O_SelD, O_SelA, O_SelB, O_Imm, O_Regwe};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the field definitions, using arithmetic on the opcode number.
    function automatic logic [33:0] ref_decode(input logic [15:0] inst);
        int          op;
        logic [4:0]  aluop;
        logic [15:0] imm;
        logic        we;
        op    = int'(inst[15:12]);
        aluop = 5'(op * 2 + int'(inst[8]));
        imm   = {8'h00, inst[7:0]};
        if (((16'h3000 >> op) & 16'h1) != 16'h0 && inst[7]) imm = imm + 16'hFF00;
        we    = ((16'h03FF >> op) & 16'h1) != 16'h0;
        return {aluop, inst[11:8], inst[7:4], inst[3:0], imm, we};
    endfunction

    // Drive one cycle's inputs, advance one edge, update the reference, settle 1 time unit.
    task automatic cycle(input logic en, input logic flush, input logic valid,
                         input logic [15:0] inst, input logic ready);
        bit p, q;
        I_En    = en;
        I_Flush = flush;
        I_Valid = valid;
        I_Inst  = inst;
        I_Ready = ready;
        @(posedge I_Clk);
        if (flush) begin
            mocc    = 0;
            exp_cnt = 16'd0;
            exp_q.delete();
        end else if (en) begin
            p = valid && (mocc < DEPTH);
            q = (mocc > 0) && ready;
            if (p) begin
                exp_q.push_back(ref_decode(inst));
                exp_cnt = exp_cnt + 16'd1;
            end
            mocc = mocc + int'(p) - int'(q);
        end
        #1;
    endtask

    always @(negedge I_Clk) begin
        if (I_Rst_n) begin
            check("o_ready", 64'(O_Ready), 64'(I_En && (exp_q.size() < DEPTH)));
            check("o_valid", 64'(O_Valid), 64'(exp_q.size() != 0));
            check("o_count", 64'(O_Count), 64'(exp_cnt));
            if (exp_q.size() != 0) begin
                check("head", 64'(dut_bundle), 64'(exp_q[0]));
                if (I_En && I_Ready) void'(exp_q.pop_front());
            end else begin
                check("idle_zero", 64'(dut_bundle), 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        I_Rst_n = 1'b0;
        I_En    = 1'b0;
        I_Flush = 1'b0;
        I_Valid = 1'b0;
        I_Inst  = 16'h0;
        I_Ready = 1'b0;
        repeat (2) @(posedge I_Clk);
        #1;
        check("rst_valid", 64'(O_Valid), 64'd0);
        check("rst_count", 64'(O_Count), 64'd0);
        check("rst_bundle", 64'(dut_bundle), 64'd0);
        @(negedge I_Clk);
        #1 I_Rst_n = 1'b1;
        @(posedge I_Clk);
        #1;

        // Basic decode
        cycle(1, 0, 1, 16'h1704, 1);
        check("bd_valid", 64'(O_Valid), 64'd1);
        check("bd_aluop", 64'(O_Aluop), 64'h03);
        check("bd_seld", 64'(O_SelD), 64'd7);
        check("bd_sela", 64'(O_SelA), 64'd0);
        check("bd_selb", 64'(O_SelB), 64'd4);
        check("bd_imm", 64'(O_Imm), 64'h0004);
        check("bd_regwe", 64'(O_Regwe), 64'd1);
        check("bd_count", 64'(O_Count), 64'd1);
        cycle(1, 0, 0, 16'h0, 1);

        // Sign extension and no-write opcode
        cycle(1, 0, 1, 16'hC8F0, 1);
        check("sx_aluop", 64'(O_Aluop), 64'h18);
        check("sx_imm", 64'(O_Imm), 64'hFFF0);
        check("sx_regwe", 64'(O_Regwe), 64'd0);
        cycle(1, 0, 1, 16'h28F0, 1);
        check("zx_imm", 64'(O_Imm), 64'h00F0);
        check("zx_regwe", 64'(O_Regwe), 64'd1);
        cycle(1, 0, 0, 16'h0, 1);

        // Backpressure
        cycle(1, 0, 1, 16'h1111, 0);
        cycle(1, 0, 1, 16'h2222, 0);
        check("bp_full_ready", 64'(O_Ready), 64'd0);
        cycle(1, 0, 1, 16'h3333, 0);
        check("bp_head_selb", 64'(O_SelB), 64'd1);
        cycle(1, 0, 0, 16'h0, 1);
        check("bp_ready_back", 64'(O_Ready), 64'd1);
        check("bp_second_selb", 64'(O_SelB), 64'd2);
        cycle(1, 0, 0, 16'h0, 1);
        check("bp_drained", 64'(O_Valid), 64'd0);

        // Stall with one entry queued
        cycle(1, 0, 1, 16'h1704, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 16'h4321, 1);
            check("st_ready", 64'(O_Ready), 64'd0);
            check("st_valid", 64'(O_Valid), 64'd1);
            check("st_seld", 64'(O_SelD), 64'd7);
        end
        cycle(1, 0, 0, 16'h0, 1);
        check("st_popped", 64'(O_Valid), 64'd0);

        // Flush with a full queue and a concurrent instruction
        cycle(1, 0, 1, 16'h5A5A, 0);
        cycle(1, 0, 1, 16'h6B6B, 0);
        cycle(1, 1, 1, 16'h7777, 0);
        check("fl_valid", 64'(O_Valid), 64'd0);
        check("fl_count", 64'(O_Count), 64'd0);
        check("fl_bundle", 64'(dut_bundle), 64'd0);
        cycle(1, 0, 0, 16'h0, 1);
        check("fl_lost", 64'(O_Valid), 64'd0);

        // Asynchronous reset with a full queue, asserted between edges
        cycle(1, 0, 1, 16'h1234, 0);
        cycle(1, 0, 1, 16'h5678, 0);
        I_Valid = 1'b0;
        #1;
        I_Rst_n = 1'b0;
        exp_q.delete();
        mocc    = 0;
        exp_cnt = 16'd0;
        #1;
        check("ar_valid", 64'(O_Valid), 64'd0);
        check("ar_count", 64'(O_Count), 64'd0);
        check("ar_bundle", 64'(dut_bundle), 64'd0);
        @(posedge I_Clk);
        @(negedge I_Clk);
        #1 I_Rst_n = 1'b1;
        @(posedge I_Clk);
        #1;
        cycle(1, 0, 1, 16'h1704, 1);
        check("ar_aluop", 64'(O_Aluop), 64'h03);
        check("ar_imm", 64'(O_Imm), 64'h0004);
        check("ar_count1", 64'(O_Count), 64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 85,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 60,
                  16'($urandom),
                  $urandom_range(0, 99) < 55);
        end
        cycle(1, 0, 0, 16'h0, 1);
        cycle(1, 0, 0, 16'h0, 1);
        cycle(1, 0, 0, 16'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_dec_pipe.md
Name: inst_dec_pipe

Overview:
- Parametrised, handshaked successor to the 16-bit RISC instruction decoder.
- Accepts raw instructions from fetch over valid/ready and decodes them into ALU op, register selects, extended immediate and register-write enable.
- Holds decoded results in a DEPTH-entry output queue so fetch is not stalled by single-cycle backpressure from the ALU/regfile stage.
- Adds stall (I_En), flush and a decoded-instruction counter.

Parameters:
- INST_W, 16, instruction width; fields below are fixed for 16.
- REG_W, 4, register-select width.
- ALUOP_W, 5, ALU op width; fixed as {opcode[3:0], mode bit}.
- IMM_W, 16, extended immediate width; must be ≥ 8.
- DEPTH, 2, output queue entries; must be ≥ 1.
- REGWE_MASK, 16'h03FF, bit n=1 means opcode n writes rd.
- SEXT_MASK, 16'h3000, bit n=1 means opcode n sign-extends imm8; otherwise it zero-extends.
- CNT_W, 16, width of the decoded-instruction counter.

Ports:
- I_Clk, in, 1, clock; all state on rising edge.
- I_Rst_n, in, 1, asynchronous active-low reset.
- I_En, in, 1, stage enable; 0 = full stall.
- I_Flush, in, 1, synchronous queue clear.
- I_Valid, in, 1, I_Inst valid.
- O_Ready, out, 1, decoder can accept.
- I_Inst, in, INST_W, raw instruction.
- O_Valid, out, 1, head entry valid.
- I_Ready, in, 1, downstream accepts head.
- O_Aluop, out, ALUOP_W, {inst[15:12], inst[8]}.
- O_SelD, out, REG_W, inst[11:8].
- O_SelA, out, REG_W, inst[7:4].
- O_SelB, out, REG_W, inst[3:0].
- O_Imm, out, IMM_W, inst[7:0] extended per SEXT_MASK.
- O_Regwe, out, 1, REGWE_MASK[inst[15:12]].
- O_Count, out, CNT_W, instructions accepted since reset/flush.

Behaviour:
- Reset (I_Rst_n=0, async): queue emptied; O_Valid=0; O_Count=0; O_Aluop, O_Sel*, O_Imm, O_Regwe all 0. Outputs are 0 whenever the queue is empty.
- Decode is combinational on I_Inst. The decoded bundle (not the raw instruction) is written into the queue on push.
- push = I_En & I_Valid & O_Ready. pop = I_En & O_Valid & I_Ready.
- O_Ready = I_En & (occupancy < DEPTH). It is derived from registered occupancy only and never depends on I_Ready.
- Latency: a push at edge k onto an empty queue shows its bundle on the outputs with O_Valid=1 from cycle k+1 (one-cycle latency).
- Ordering is strict FIFO. Head outputs are stable while O_Valid=1 and no pop occurs.
- Simultaneous push and pop: occupancy unchanged.
  - Empty queue: no bypass; the pushed entry appears next cycle.
  - Full queue: push is impossible because O_Ready=0.
- I_En=0: no push, no pop, O_Ready=0; queue, outputs and counter hold. O_Valid keeps its value.
- I_Flush=1 (when I_En=1 or 0): at the next edge the queue empties, O_Valid=0 and O_Count=0. A push or pop in the same cycle is discarded. Flush has priority over everything except reset.
- O_Count increments by 1 on each push and wraps from 2^CNT_W−1 to 0.
- Queue pointers are log2(DEPTH) bits (min 1). They wrap modulo DEPTH, and occupancy is a separate 0..DEPTH counter. DEPTH need not be a power of two.
- Opcodes outside both masks are decoded the same way (no illegal-op trap). O_Regwe=0 for those cleared in REGWE_MASK.
- Reset asserted mid-stream discards all queued entries. The first edge after deassertion behaves as from empty.

Test Plan:
- Basic decode: reset, I_En=1, push 16'h1704 with I_Ready=1 → next cycle O_Valid=1, O_Aluop=5'h03, O_SelD=7, O_SelA=0, O_SelB=4, O_Imm=16'h0004, O_Regwe=1, O_Count=1.
- Sign-extend/no-write: push 16'hC8F0 → O_Aluop=5'h18, O_Imm=16'hFFF0, O_Regwe=0. Push 16'h28F0 → O_Imm=16'h00F0, O_Regwe=1.
- Backpressure: I_Ready=0, push 16'h1111, 16'h2222 → O_Ready=0 after the second push and a third valid is not taken. Head stays 16'h1111 decode. Raise I_Ready → 1111, then 2222 drain in order; O_Ready returns to 1 the cycle after the first pop.
- Stall: with 1 entry queued, drop I_En for 3 cycles while I_Valid=I_Ready=1 → O_Ready=0, outputs, O_Valid and O_Count frozen. On re-enable the entry pops.
- Flush: queue full, assert I_Flush together with I_Valid → next cycle O_Valid=0, O_Count=0, all outputs 0, and the concurrent instruction is lost.
- Async reset mid-operation: assert I_Rst_n=0 between clock edges with the queue full → outputs go 0 immediately, without waiting for a clock edge. After release, push 16'h1704 → decodes as in the basic-decode scenario, O_Count=1.
